ctrl_cmd_sequencer: RTL and testbench



---
 rtl/ctrl_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ctrl_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_cmd_sequencer.sv
// Control-channel command sequencer: parses 5-word commands from the SPI RX FIFO,
// issues register write/read strobes and returns read data to the TX FIFO MSB first.
module ctrl_cmd_sequencer #(
    parameter int unsigned         ADDR_WD      = 16,
    parameter int unsigned         DATA_WD      = 16,
    parameter int unsigned         RD_TIMEOUT   = 64,
    parameter logic [DATA_WD-1:0]  TIMEOUT_DATA = DATA_WD'(16'hFFFF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:0]         iv_rx_data,
    input  logic               i_rx_empty,
    output logic               o_rx_rd_en,
    output logic [7:0]         ov_tx_data,
    output logic               o_tx_wr_en,
    input  logic               i_tx_full,
    output logic [ADDR_WD-1:0] ov_addr,
    output logic [DATA_WD-1:0] ov_wr_data,
    output logic               o_wr_en,
    output logic               o_rd_en,
    input  logic [DATA_WD-1:0] iv_rd_data,
    input  logic               i_rd_valid,
    output logic               o_busy,
    output logic               o_cmd_err
);

    localparam int unsigned CNT_WD = $clog2(RD_TIMEOUT + 1);
    localparam logic [8:0]  OP_WR  = 9'h180;
    localparam logic [8:0]  OP_RD  = 9'h181;

    typedef enum logic [3:0] {
        IDLE, GET_AH, GET_AL, GET_DH, GET_DL,
        EXEC_WR, EXEC_RD, WAIT_RD, PUSH_H, PUSH_L
    } state_t;

    state_t              state, state_nxt;
    logic                is_rd, is_rd_nxt;
    logic [7:0]          addr_hi, addr_hi_nxt;
    logic [7:0]          addr_lo, addr_lo_nxt;
    logic [7:0]          data_hi, data_hi_nxt;
    logic [DATA_WD-1:0]  rd_latch, rd_latch_nxt;
    logic [CNT_WD-1:0]   rd_cnt, rd_cnt_nxt;
    logic [ADDR_WD-1:0]  addr_nxt;
    logic [DATA_WD-1:0]  wr_data_nxt;
    logic [7:0]          tx_data_nxt;
    logic                wr_en_nxt, rd_en_nxt, tx_wr_en_nxt, cmd_err_nxt;

    // RX words are only consumed while collecting a command
    assign o_rx_rd_en = !i_rx_empty &&
                        (state inside {IDLE, GET_AH, GET_AL, GET_DH, GET_DL});
    assign o_busy     = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        is_rd_nxt    = is_rd;
        addr_hi_nxt  = addr_hi;
        addr_lo_nxt  = addr_lo;
        data_hi_nxt  = data_hi;
        rd_latch_nxt = rd_latch;
        rd_cnt_nxt   = rd_cnt;
        addr_nxt     = ov_addr;
        wr_data_nxt  = ov_wr_data;
        tx_data_nxt  = ov_tx_data;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        tx_wr_en_nxt = 1'b0;
        cmd_err_nxt  = 1'b0;

        case (state)
            IDLE, GET_AH, GET_AL, GET_DH, GET_DL: begin
                if (o_rx_rd_en) begin
                    if (iv_rx_data[8]) begin
                        // A start flag always restarts parsing; mid-command it is a resync
                        cmd_err_nxt = (state != IDLE) ||
                                      !((iv_rx_data == OP_WR) || (iv_rx_data == OP_RD));
                        if (iv_rx_data == OP_WR) begin
                            is_rd_nxt = 1'b0;
                            state_nxt = GET_AH;
                        end else if (iv_rx_data == OP_RD) begin
                            is_rd_nxt = 1'b1;
                            state_nxt = GET_AH;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        case (state)
                            GET_AH: begin
                                addr_hi_nxt = iv_rx_data[7:0];
                                state_nxt   = GET_AL;
                            end
                            GET_AL: begin
                                addr_lo_nxt = iv_rx_data[7:0];
                                state_nxt   = GET_DH;
                            end
                            GET_DH: begin
                                data_hi_nxt = iv_rx_data[7:0];
                                state_nxt   = GET_DL;
                            end
                            GET_DL: begin
                                addr_nxt = ADDR_WD'({addr_hi, addr_lo});
                                if (is_rd) begin
                                    rd_en_nxt = 1'b1;
                                    state_nxt = EXEC_RD;
                                end else begin
                                    wr_data_nxt = DATA_WD'({data_hi, iv_rx_data[7:0]});
                                    wr_en_nxt   = 1'b1;
                                    state_nxt   = EXEC_WR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            EXEC_WR: state_nxt = IDLE;
            EXEC_RD: begin
                // Counter holds cycles elapsed since the read strobe
                rd_cnt_nxt = CNT_WD'(1);
                state_nxt  = WAIT_RD;
            end
            WAIT_RD: begin
                if (i_rd_valid) begin
                    rd_latch_nxt = iv_rd_data;
                    state_nxt    = PUSH_H;
                end else if (rd_cnt >= CNT_WD'(RD_TIMEOUT - 1)) begin
                    rd_latch_nxt = TIMEOUT_DATA;
                    cmd_err_nxt  = 1'b1;
                    state_nxt    = PUSH_H;
                end else begin
                    rd_cnt_nxt = rd_cnt + CNT_WD'(1);
                end
            end
            PUSH_H: begin
                if (!i_tx_full) begin
                    tx_wr_en_nxt = 1'b1;
                    tx_data_nxt  = rd_latch[DATA_WD-1 -: 8];
                    state_nxt    = PUSH_L;
                end
            end
            PUSH_L: begin
                if (!i_tx_full) begin
                    tx_wr_en_nxt = 1'b1;
                    tx_data_nxt  = rd_latch[7:0];
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            is_rd      <= 1'b0;
            addr_hi    <= '0;
            addr_lo    <= '0;
            data_hi    <= '0;
            rd_latch   <= '0;
            rd_cnt     <= '0;
            ov_addr    <= '0;
            ov_wr_data <= '0;
            ov_tx_data <= '0;
            o_wr_en    <= 1'b0;
            o_rd_en    <= 1'b0;
            o_tx_wr_en <= 1'b0;
            o_cmd_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            is_rd      <= is_rd_nxt;
            addr_hi    <= addr_hi_nxt;
            addr_lo    <= addr_lo_nxt;
            data_hi    <= data_hi_nxt;
            rd_latch   <= rd_latch_nxt;
            rd_cnt     <= rd_cnt_nxt;
            ov_addr    <= addr_nxt;
            ov_wr_data <= wr_data_nxt;
            ov_tx_data <= tx_data_nxt;
            o_wr_en    <= wr_en_nxt;
            o_rd_en    <= rd_en_nxt;
            o_tx_wr_en <= tx_wr_en_nxt;
            o_cmd_err  <= cmd_err_nxt;
        end
    end

endmodule

// File: tb/tb_ctrl_cmd_sequencer.sv
// Bench for ctrl_cmd_sequencer: RX FIFO model, register bank responder and
// scoreboard queues for write strobes, read strobes and TX bytes.
module tb_ctrl_cmd_sequencer;

    localparam int unsigned RD_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  iv_rx_data;
    logic        i_rx_empty;
    logic        o_rx_rd_en;
    logic [7:0]  ov_tx_data;
    logic        o_tx_wr_en;
    logic        i_tx_full;
    logic [15:0] ov_addr;
    logic [15:0] ov_wr_data;
    logic        o_wr_en;
    logic        o_rd_en;
    logic [15:0] iv_rd_data;
    logic        i_rd_valid;
    logic        o_busy;
    logic        o_cmd_err;

    ctrl_cmd_sequencer #(
        .ADDR_WD(16), .DATA_WD(16), .RD_TIMEOUT(RD_TIMEOUT), .TIMEOUT_DATA(16'hFFFF)
    ) dut (
        .clk(clk), .reset(reset),
        .iv_rx_data(iv_rx_data), .i_rx_empty(i_rx_empty), .o_rx_rd_en(o_rx_rd_en),
        .ov_tx_data(ov_tx_data), .o_tx_wr_en(o_tx_wr_en), .i_tx_full(i_tx_full),
        .ov_addr(ov_addr), .ov_wr_data(ov_wr_data), .o_wr_en(o_wr_en), .o_rd_en(o_rd_en),
        .iv_rd_data(iv_rd_data), .i_rd_valid(i_rd_valid),
        .o_busy(o_busy), .o_cmd_err(o_cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          nw;
        logic [8:0]  w [8];
        int          delay;
        logic [15:0] resp;
        bit          has_wr;
        logic [15:0] wa;
        logic [15:0] wd;
        bit          has_rd;
        logic [15:0] ra;
        int          err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          rd_cyc = 0, err_cyc = 0, tx_cyc_prev = 0, tx_cyc_last = 0;
    int          resp_delay = -1;
    logic [15:0] resp_data = 16'h0;
    bit          rx_pop = 1'b0;
    logic [8:0]  rx_q [$];
    wr_t         exp_wr [$];
    logic [15:0] exp_rd [$];
    logic [7:0]  exp_tx [$];
    wr_t         mon_w;
    logic [15:0] mon_a;
    logic [7:0]  mon_b;
    vec_t        tv [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RX FIFO model: first-word-fall-through, pops when the DUT accepted at the edge
    always @(negedge clk) rx_pop = o_rx_rd_en;
    always @(posedge clk) begin
        #1;
        if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_pop = 1'b0;
        if (rx_q.size() > 0) begin
            iv_rx_data = rx_q[0];
            i_rx_empty = 1'b0;
        end else begin
            iv_rx_data = 9'h0;
            i_rx_empty = 1'b1;
        end
    end

    // Register bank: valid arrives resp_delay cycles after the first WAIT cycle
    always @(negedge clk) begin
        if (!reset && o_rd_en && resp_delay >= 0) begin
            @(negedge clk);
            repeat (resp_delay) @(negedge clk);
            i_rd_valid = 1'b1;
            iv_rd_data = resp_data;
            @(negedge clk);
            i_rd_valid = 1'b0;
            iv_rd_data = 16'h0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (o_wr_en) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got addr %h data %h expected none", ov_addr, ov_wr_data);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 32'(ov_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(ov_wr_data), 32'(mon_w.data));
                end
            end
            if (o_rd_en) begin
                rd_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got addr %h expected none", ov_addr);
                end else begin
                    mon_a = exp_rd.pop_front();
                    check("rd_addr", 32'(ov_addr), 32'(mon_a));
                end
            end
            if (o_tx_wr_en) begin
                tx_cyc_prev = tx_cyc_last;
                tx_cyc_last = cyc;
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got %h expected none", ov_tx_data);
                end else begin
                    mon_b = exp_tx.pop_front();
                    check("tx_byte", 32'(ov_tx_data), 32'(mon_b));
                end
            end
            if (o_cmd_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rx_q.size() > 0 || o_busy || exp_wr.size() > 0 || exp_rd.size() > 0 ||
                exp_tx.size() > 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_complete"}, 32'(n < 400), 32'd1);
        rx_q.delete(); exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    endtask

    task automatic send(input logic [8:0] w);
        rx_q.push_back(w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int n;
        reset      = 1'b1;
        i_rx_empty = 1'b1;
        iv_rx_data = 9'h0;
        i_tx_full  = 1'b0;
        i_rd_valid = 1'b0;
        iv_rd_data = 16'h0;

        tv[0] = '{nw:5, w:'{9'h180,9'h000,9'h055,9'h0AB,9'h056,9'h0,9'h0,9'h0}, delay:-1, resp:16'h0,
                  has_wr:1, wa:16'h0055, wd:16'hAB56, has_rd:0, ra:16'h0, err:0};
        tv[1] = '{nw:5, w:'{9'h181,9'h000,9'h055,9'h000,9'h000,9'h0,9'h0,9'h0}, delay:2, resp:16'hAB56,
                  has_wr:0, wa:16'h0, wd:16'h0, has_rd:1, ra:16'h0055, err:0};
        tv[2] = '{nw:5, w:'{9'h180,9'h001,9'h064,9'h074,9'h088,9'h0,9'h0,9'h0}, delay:-1, resp:16'h0,
                  has_wr:1, wa:16'h0164, wd:16'h7488, has_rd:0, ra:16'h0, err:0};
        tv[3] = '{nw:5, w:'{9'h181,9'h001,9'h064,9'h0D7,9'h090,9'h0,9'h0,9'h0}, delay:0, resp:16'h7488,
                  has_wr:0, wa:16'h0, wd:16'h0, has_rd:1, ra:16'h0164, err:0};
        tv[4] = '{nw:8, w:'{9'h180,9'h000,9'h040,9'h181,9'h000,9'h040,9'h000,9'h000}, delay:1, resp:16'h1234,
                  has_wr:0, wa:16'h0, wd:16'h0, has_rd:1, ra:16'h0040, err:1};
        tv[5] = '{nw:2, w:'{9'h055,9'h1A5,9'h0,9'h0,9'h0,9'h0,9'h0,9'h0}, delay:-1, resp:16'h0,
                  has_wr:0, wa:16'h0, wd:16'h0, has_rd:0, ra:16'h0, err:1};
        tv[6] = '{nw:5, w:'{9'h180,9'h0FF,9'h0FF,9'h0FF,9'h0FF,9'h0,9'h0,9'h0}, delay:-1, resp:16'h0,
                  has_wr:1, wa:16'hFFFF, wd:16'hFFFF, has_rd:0, ra:16'h0, err:0};
        tv[7] = '{nw:5, w:'{9'h181,9'h0FF,9'h0FF,9'h000,9'h000,9'h0,9'h0,9'h0}, delay:5, resp:16'h0000,
                  has_wr:0, wa:16'h0, wd:16'h0, has_rd:1, ra:16'hFFFF, err:0};
        tv[8] = '{nw:6, w:'{9'h181,9'h180,9'h000,9'h012,9'h034,9'h056,9'h0,9'h0}, delay:-1, resp:16'h0,
                  has_wr:1, wa:16'h0012, wd:16'h3456, has_rd:0, ra:16'h0, err:1};

        repeat (3) @(negedge clk);
        check("reset_flags", 32'({o_rx_rd_en, o_tx_wr_en, o_wr_en, o_rd_en, o_busy, o_cmd_err}), 32'd0);
        check("reset_buses", 32'({ov_addr, ov_wr_data}), 32'd0);
        check("reset_tx_data", 32'(ov_tx_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            e0 = err_cnt;
            resp_delay = tv[i].delay;
            resp_data  = tv[i].resp;
            if (tv[i].has_wr) exp_wr.push_back('{addr: tv[i].wa, data: tv[i].wd});
            if (tv[i].has_rd) begin
                exp_rd.push_back(tv[i].ra);
                exp_tx.push_back(tv[i].resp[15:8]);
                exp_tx.push_back(tv[i].resp[7:0]);
            end
            for (int k = 0; k < tv[i].nw; k++) send(tv[i].w[k]);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(tv[i].err));
        end

        // Read timeout: no valid ever, FF FF returned, error exactly RD_TIMEOUT after strobe
        e0 = err_cnt;
        resp_delay = -1;
        exp_rd.push_back(16'h00B4);
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hFF);
        send(9'h181); send(9'h000); send(9'h0B4); send(9'h000); send(9'h000);
        wait_idle("timeout");
        check("timeout_err", 32'(err_cnt - e0), 32'd1);
        check("timeout_err_delay", 32'(err_cyc - rd_cyc), 32'(RD_TIMEOUT));
        check("rd_keeps_wr_data", 32'(ov_wr_data), 32'h3456);
        check("rd_addr_held", 32'(ov_addr), 32'h00B4);

        // TX backpressure with a stray word waiting in the RX FIFO
        e0 = err_cnt;
        i_tx_full  = 1'b1;
        resp_delay = 0;
        resp_data  = 16'h5AA5;
        exp_rd.push_back(16'h00C3);
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hA5);
        send(9'h181); send(9'h000); send(9'h0C3); send(9'h000); send(9'h000); send(9'h055);
        repeat (15) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold", 32'({o_tx_wr_en, o_busy, o_rx_rd_en, i_rx_empty}), 32'b0100);
        end
        i_tx_full = 1'b0;
        wait_idle("backpressure");
        check("bp_consecutive", 32'(tx_cyc_last - tx_cyc_prev), 32'd1);
        check("bp_err", 32'(err_cnt - e0), 32'd0);

        // Reset after the GET_AL word drops the partial command
        send(9'h180); send(9'h000); send(9'h040);
        n = 0;
        while (rx_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("pre_reset_busy", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_flags", 32'({o_rx_rd_en, o_tx_wr_en, o_wr_en, o_rd_en, o_busy, o_cmd_err}), 32'd0);
        check("async_reset_buses", 32'({ov_addr, ov_wr_data}), 32'd0);
        rx_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        e0 = err_cnt;
        exp_wr.push_back('{addr: 16'h0077, data: 16'h12EF});
        send(9'h180); send(9'h000); send(9'h077); send(9'h012); send(9'h0EF);
        wait_idle("post_reset");
        check("post_reset_err", 32'(err_cnt - e0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
